// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority voting and a one-entry valid/ready
// holding register.
// Ports:
//   i_clk, i_rst_n   system clock, async active-low reset
//   i_uart_rx        asynchronous serial line, idle high
//   o_data           received byte, stable while o_valid
//   o_valid/i_ready  holding-register handshake
//   o_frame_err      stop bit sampled low (qualifies o_data)
//   o_parity_err     parity mismatch (qualifies o_data)
//   o_overrun        one-cycle pulse when a completed frame is dropped
//   o_busy           frame in progress
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned M   = OVERSAMPLE / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Elaboration-time parameter sanity checks
  if (DIV < 1) begin : g_div_check
    $error("uart_rx_os: CLK_FREQ too low for BAUD*OVERSAMPLE (DIV < 1)");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8) || (PARITY > 2)) begin : g_fmt_check
    $error("uart_rx_os: DATA_BITS must be 5..8 and PARITY 0..2");
  end

  logic [2:0]           state, state_nxt;
  logic                 sync1, sync2, hist;
  logic [1:0]           arm;
  logic                 fall, start_edge;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [CW-1:0]        cnt, cnt_inc;
  logic                 s_lo, s_mid, decide, bit_end;
  logic                 smp_a, smp_b, vote;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 par_err, par_exp;
  logic                 frame_done;

  // Two-FF synchroniser; history only ever holds real line samples, so a line
  // that is low out of reset cannot produce a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      arm   <= 2'b00;
      hist  <= 1'b0;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
      arm   <= {arm[0], 1'b1};
      hist  <= arm[1] & sync2;
    end
  end

  assign fall       = hist & ~sync2;
  assign start_edge = (state == S_IDLE) && fall;

  // Prescaler and per-bit tick counter, both realigned to the start edge
  assign tick    = (presc == PW'(DIV - 1));
  assign cnt_inc = (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (start_edge) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) cnt <= cnt_inc;
    end
  end

  // Strobes keyed on the count each tick reaches; bit_end is the wrap
  assign s_lo    = tick && (cnt_inc == CW'(M - 1));
  assign s_mid   = tick && (cnt_inc == CW'(M));
  assign decide  = tick && (cnt_inc == CW'(M + 1));
  assign bit_end = tick && (cnt_inc == '0);

  // Three-sample majority vote; third sample is the live synced line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (s_lo)  smp_a <= sync2;
      if (s_mid) smp_b <= sync2;
    end
  end

  assign vote    = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
  assign par_exp = (PARITY == 1) ? ~(^shreg) : ^shreg;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  if (fall) state_nxt = S_START;
      S_START: begin
        if (decide && vote) state_nxt = S_IDLE;
        else if (bit_end)   state_nxt = S_DATA;
      end
      S_DATA:  if (bit_end && (bit_idx == BW'(DATA_BITS - 1)))
                 state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_nxt = S_STOP;
      S_STOP:  if (decide) begin
                 state_nxt  = S_IDLE;
                 frame_done = 1'b1;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame datapath: LSB-first shift, bit index, parity check
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_err <= 1'b0;
    end else begin
      if (start_edge) begin
        bit_idx <= '0;
        par_err <= 1'b0;
      end
      if ((state == S_DATA) && decide)  shreg   <= {vote, shreg[DATA_BITS-1:1]};
      if ((state == S_DATA) && bit_end) bit_idx <= bit_idx + BW'(1);
      if ((state == S_PAR) && decide)   par_err <= vote ^ par_exp;
    end
  end

  // Holding register, overrun pulse and busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_busy    <= (state_nxt != S_IDLE);
      if (frame_done) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_frame_err  <= ~vote;
          o_parity_err <= par_err;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid      <= 1'b0;
        o_frame_err  <= 1'b0;
        o_parity_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: one 8N1 instance and one 8E1 instance, directed
// scenarios plus randomized frames, scored against a frame-level model.
module tb_uart_rx_os;

  localparam int BIT = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_n, rx_e, ready_n, ready_e;
  logic [7:0] o_data_n, o_data_e;
  logic       o_valid_n, o_valid_e;
  logic       o_frame_err_n, o_frame_err_e;
  logic       o_parity_err_n, o_parity_err_e;
  logic       o_overrun_n, o_overrun_e;
  logic       o_busy_n, o_busy_e;

  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   t_start = 0;
  int   ovr_seen [2];
  int   ovr_exp  [2];
  int   xfer_cnt [2];
  logic prev_valid [2];
  logic prev_xfer  [2];
  logic [7:0] prev_data [2];
  logic [7:0] last_d [2];
  logic last_fe [2];
  logic last_pe [2];
  rec_t exp_n[$];
  rec_t exp_e[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_n),
    .o_data(o_data_n), .o_valid(o_valid_n), .i_ready(ready_n),
    .o_frame_err(o_frame_err_n), .o_parity_err(o_parity_err_n),
    .o_overrun(o_overrun_n), .o_busy(o_busy_n));

  uart_rx_os #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(2)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_e),
    .o_data(o_data_e), .o_valid(o_valid_e), .i_ready(ready_e),
    .o_frame_err(o_frame_err_e), .o_parity_err(o_parity_err_e),
    .o_overrun(o_overrun_e), .o_busy(o_busy_e));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests_run++;
    if (act < lo || act > hi) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_n"}, 32'({o_valid_n, o_data_n, o_frame_err_n, o_parity_err_n, o_overrun_n, o_busy_n}), 32'd0);
    check({name, "_e"}, 32'({o_valid_e, o_data_e, o_frame_err_e, o_parity_err_e, o_overrun_e, o_busy_e}), 32'd0);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) rx_n = v;
    else        rx_e = v;
  endtask

  // Drive one frame bit by bit; the line is left idle high afterwards
  task automatic send_raw(input int w, input logic [7:0] d, input bit use_par,
                          input bit pbit, input bit sbit, input int blen);
    set_line(w, 1'b0);
    t_start = cyc;
    wait_clks(blen);
    for (int i = 0; i < 8; i++) begin
      set_line(w, d[i]);
      wait_clks(blen);
    end
    if (use_par) begin
      set_line(w, pbit);
      wait_clks(blen);
    end
    set_line(w, sbit);
    wait_clks(blen);
    set_line(w, 1'b1);
  endtask

  // Model: what the consumer must see for a frame with these line bits
  task automatic expect_frame(input int w, input logic [7:0] d, input bit pbit, input bit sbit);
    rec_t r;
    r.d  = d;
    r.fe = ~sbit;
    r.pe = (w == 1) ? (pbit != (^d)) : 1'b0;
    if (w == 0) exp_n.push_back(r);
    else        exp_e.push_back(r);
  endtask

  task automatic send(input int w, input logic [7:0] d, input bit pbit, input bit sbit, input int blen);
    expect_frame(w, d, pbit, sbit);
    send_raw(w, d, (w == 1), pbit, sbit, blen);
  endtask

  // Per-cycle comparison of one instance against the model
  task automatic cmp_inst(input int w, input logic v, input logic [7:0] d, input logic fe,
                          input logic pe, input logic ov, input logic rdy);
    rec_t r;
    if (prev_xfer[w])
      check($sformatf("valid_clears_%0d", w), 32'(v), 32'd0);
    else if (prev_valid[w] && v)
      check($sformatf("data_hold_%0d", w), 32'(d), 32'(prev_data[w]));
    if (!v) check($sformatf("flags_clear_%0d", w), 32'({fe, pe}), 32'd0);
    if (ov) begin
      ovr_seen[w]++;
      check($sformatf("overrun_full_%0d", w), 32'(v), 32'd1);
    end
    if (v && rdy) begin
      xfer_cnt[w]++;
      last_d[w]  = d;
      last_fe[w] = fe;
      last_pe[w] = pe;
      if ((w == 0 && exp_n.size() == 0) || (w == 1 && exp_e.size() == 0)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_byte_%0d: got 0x%0h, expected no byte", w, d);
      end else begin
        if (w == 0) r = exp_n.pop_front();
        else        r = exp_e.pop_front();
        check($sformatf("rx_data_%0d", w), 32'(d), 32'(r.d));
        check($sformatf("rx_frame_err_%0d", w), 32'(fe), 32'(r.fe));
        check($sformatf("rx_parity_err_%0d", w), 32'(pe), 32'(r.pe));
      end
    end
    prev_valid[w] = v;
    prev_xfer[w]  = v && rdy;
    prev_data[w]  = d;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        prev_valid[w] = 1'b0;
        prev_xfer[w]  = 1'b0;
      end
    end else begin
      cmp_inst(0, o_valid_n, o_data_n, o_frame_err_n, o_parity_err_n, o_overrun_n, ready_n);
      cmp_inst(1, o_valid_e, o_data_e, o_frame_err_e, o_parity_err_e, o_overrun_e, ready_e);
    end
  end

  initial begin
    int xc, ov0, lat, drop, t0, busy_seen;
    logic [7:0] d;
    bit sb, pb;

    for (int w = 0; w < 2; w++) begin
      ovr_seen[w] = 0; ovr_exp[w] = 0; xfer_cnt[w] = 0;
      prev_valid[w] = 1'b0; prev_xfer[w] = 1'b0; prev_data[w] = 8'h00;
      last_d[w] = 8'h00; last_fe[w] = 1'b0; last_pe[w] = 1'b0;
    end
    rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b1; ready_e = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clks(20);

    // 8N1 0xA5, latency and single-cycle valid
    xc = xfer_cnt[0];
    lat = -1;
    fork
      send(0, 8'hA5, 1'b0, 1'b1, BIT);
      begin
        for (int i = 0; i < 900 && lat < 0; i++) begin
          @(negedge clk);
          if (o_valid_n) lat = cyc - t_start;
        end
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(o_valid_n), 32'd0);
      end
    join
    check_range("t1_latency", lat, 602, 618);
    wait_clks(20);
    check("t1_xfers", 32'(xfer_cnt[0] - xc), 32'd1);
    check("t1_data", 32'(last_d[0]), 32'hA5);
    check("t1_errs", 32'({last_fe[0], last_pe[0]}), 32'd0);

    // 20-clk low glitch, then 0x3C
    xc = xfer_cnt[0];
    set_line(0, 1'b0);
    t0 = cyc;
    wait_clks(20);
    set_line(0, 1'b1);
    @(negedge clk);
    check("t2_glitch_busy", 32'(o_busy_n), 32'd1);
    drop = 1000;
    for (int i = 0; i < 100 && drop == 1000; i++) begin
      if (!o_busy_n) drop = cyc - t0;
      else @(negedge clk);
    end
    check_range("t2_busy_drop", drop, 1, 40);
    wait_clks(50);
    send(0, 8'h3C, 1'b0, 1'b1, BIT);
    wait_clks(20);
    check("t2_xfers", 32'(xfer_cnt[0] - xc), 32'd1);
    check("t2_data", 32'(last_d[0]), 32'h3C);

    // Framing error, then clean 0x55
    send(0, 8'h3C, 1'b0, 1'b0, BIT);
    wait_clks(100);
    check("t3_data", 32'(last_d[0]), 32'h3C);
    check("t3_frame_err", 32'(last_fe[0]), 32'd1);
    send(0, 8'h55, 1'b0, 1'b1, BIT);
    wait_clks(20);
    check("t3_clean_data", 32'(last_d[0]), 32'h55);
    check("t3_clean_fe", 32'(last_fe[0]), 32'd0);

    // Even parity on 0x07
    send(1, 8'h07, 1'b0, 1'b1, BIT);
    wait_clks(20);
    check("t4_bad_par_data", 32'(last_d[1]), 32'h07);
    check("t4_bad_par_pe", 32'(last_pe[1]), 32'd1);
    send(1, 8'h07, 1'b1, 1'b1, BIT);
    wait_clks(20);
    check("t4_good_par_pe", 32'(last_pe[1]), 32'd0);

    // Break: one frame of zeros with framing error, then nothing
    xc = xfer_cnt[0];
    expect_frame(0, 8'h00, 1'b0, 1'b0);
    set_line(0, 1'b0);
    wait_clks(15 * BIT);
    @(negedge clk);
    check("brk_busy", 32'(o_busy_n), 32'd0);
    check("brk_xfers", 32'(xfer_cnt[0] - xc), 32'd1);
    check("brk_frame", 32'({last_d[0], last_fe[0]}), 32'h001);
    @(posedge clk); #1;
    set_line(0, 1'b1);
    wait_clks(100);
    check("brk_no_more", 32'(xfer_cnt[0] - xc), 32'd1);

    // Overrun with consumer stalled
    ready_n = 1'b0;
    xc = xfer_cnt[0];
    ov0 = ovr_seen[0];
    expect_frame(0, 8'h11, 1'b0, 1'b1);
    send_raw(0, 8'h11, 1'b0, 1'b0, 1'b1, BIT);
    send_raw(0, 8'h22, 1'b0, 1'b0, 1'b1, BIT);
    ovr_exp[0]++;
    wait_clks(10);
    @(negedge clk);
    check("t5_held_valid", 32'(o_valid_n), 32'd1);
    check("t5_held_data", 32'(o_data_n), 32'h11);
    check("t5_one_overrun", 32'(ovr_seen[0] - ov0), 32'd1);
    @(posedge clk); #1;
    ready_n = 1'b1;
    wait_clks(5);
    check("t5_xfers", 32'(xfer_cnt[0] - xc), 32'd1);
    check("t5_xfer_data", 32'(last_d[0]), 32'h11);
    check("t5_drained", 32'(o_valid_n), 32'd0);

    // Reset during data bit 4 with the line low
    xc = xfer_cnt[0];
    busy_seen = 0;
    fork
      send_raw(0, 8'h00, 1'b0, 1'b0, 1'b1, BIT);
      begin
        wait_clks(5 * BIT + 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_in_reset");
        wait_clks(10);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (o_busy_n || o_valid_n) busy_seen++;
        end
      end
    join
    check("t6_no_start_after_reset", 32'(busy_seen), 32'd0);
    wait_clks(100);
    check("t6_no_frame", 32'(xfer_cnt[0] - xc), 32'd0);
    send(0, 8'h5A, 1'b0, 1'b1, BIT);
    wait_clks(20);
    check("t6_after_data", 32'(last_d[0]), 32'h5A);
    check("t6_after_errs", 32'({last_fe[0], last_pe[0]}), 32'd0);

    // Randomized frames on both instances: data, stop/parity bits, baud skew, gaps
    fork
      for (int k = 0; k < 12; k++) begin
        d  = 8'($urandom);
        sb = ($urandom_range(0, 5) != 0);
        send(0, d, 1'b0, sb, $urandom_range(62, 66));
        wait_clks(sb ? $urandom_range(0, 30) : $urandom_range(10, 40));
      end
      for (int k = 0; k < 10; k++) begin
        automatic logic [7:0] de = 8'($urandom);
        automatic bit sbe = ($urandom_range(0, 5) != 0);
        pb = ($urandom_range(0, 1) != 0);
        send(1, de, pb, sbe, $urandom_range(62, 66));
        wait_clks(sbe ? $urandom_range(0, 30) : $urandom_range(10, 40));
      end
    join

    wait_clks(200);
    check("n_queue_empty", 32'(exp_n.size()), 32'd0);
    check("e_queue_empty", 32'(exp_e.size()), 32'd0);
    check("n_overruns", 32'(ovr_seen[0]), 32'(ovr_exp[0]));
    check("e_overruns", 32'(ovr_seen[1]), 32'(ovr_exp[1]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
